// File: rtl/multi_sel_pkg.sv
// Shared state type and default geometry for the multi_sel_seq coefficient sequencer.
// The default coefficient set (1,3,7,8) is packed low coefficient first.
package multi_sel_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_COEF = 4;
    localparam int DEF_COEF_W   = 4;

    localparam logic [DEF_NUM_COEF*DEF_COEF_W-1:0] DEF_COEFS = 16'h8731;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/const_shift_add_mul.sv
// Unsigned DATA_W x COEF_W multiplier built from shifted copies of the sample,
// one per set coefficient bit; purely combinational, registered by the caller.
module const_shift_add_mul
    import multi_sel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W
) (
    input  logic [DATA_W-1:0]        a,
    input  logic [COEF_W-1:0]        coef,
    output logic [DATA_W+COEF_W-1:0] prod
);

    localparam int P_W = DATA_W + COEF_W;

    logic [P_W-1:0] a_ext;

    assign a_ext = {{COEF_W{1'b0}}, a};

    // The full-width accumulator cannot overflow: the largest sum is (2^DATA_W-1)(2^COEF_W-1).
    always_comb begin
        prod = '0;
        for (int b = 0; b < COEF_W; b++) begin
            if (coef[b]) begin
                prod = prod + (a_ext << b);
            end
        end
    end

endmodule

// File: rtl/multi_sel_seq.sv
// Sequencer that emits sample x COEF[i] for i = 0..NUM_COEF-1 on a valid/ready stream.
// Define MULTI_SEL_B2B_EN to accept the next sample on the last beat with no bubble.
module multi_sel_seq
    import multi_sel_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_COEF = DEF_NUM_COEF,
    parameter int COEF_W   = DEF_COEF_W,
    parameter logic [NUM_COEF*COEF_W-1:0] COEFS = DEF_COEFS,
    localparam int IDX_W   = $clog2(NUM_COEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     input_grant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W+COEF_W-1:0] out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last
);

    localparam int P_W = DATA_W + COEF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);

    state_t state;

    logic [DATA_W-1:0] d_reg;
    logic              accept;
    logic              beat;
    logic [IDX_W-1:0]  idx_next;
    logic [IDX_W-1:0]  idx_sel;
    logic [DATA_W-1:0] mul_a;
    logic [COEF_W-1:0] mul_coef;
    logic [P_W-1:0]    mul_prod;

    assign beat     = out_valid & out_ready;
    assign idx_next = out_idx + 1'b1;

`ifdef MULTI_SEL_B2B_EN
    assign in_ready = (state == IDLE) | (beat & out_last);
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept = in_valid & in_ready;

    // On the last beat idx_next may point past the table, so clamp it; that product is unused.
    assign idx_sel = out_last ? out_idx : idx_next;

    // A fresh sample always starts at COEF[0]; otherwise the held sample feeds the next coefficient.
    always_comb begin
        mul_a    = d_reg;
        mul_coef = COEFS[idx_sel*COEF_W +: COEF_W];
        if (accept) begin
            mul_a    = in_data;
            mul_coef = COEFS[COEF_W-1:0];
        end
    end

    const_shift_add_mul #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_mul (
        .a    (mul_a),
        .coef (mul_coef),
        .prod (mul_prod)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            d_reg       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            out_last    <= 1'b0;
            input_grant <= 1'b0;
        end else begin
            input_grant <= accept;
            if (accept) begin
                state     <= RUN;
                d_reg     <= in_data;
                out_data  <= mul_prod;
                out_idx   <= '0;
                out_valid <= 1'b1;
                out_last  <= (NUM_COEF == 1);
            end else if (state == RUN && beat) begin
                if (out_last) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    out_idx  <= idx_next;
                    out_data <= mul_prod;
                    out_last <= (idx_next == LAST_IDX);
                end
            end
        end
    end

endmodule

// File: doc/multi_sel_seq.md
# multi_sel_seq

Parametrised sequential constant-multiplier sequencer. Accepts one unsigned DATA_W-bit sample through a valid/ready handshake. Emits NUM_COEF products, sample × COEF[i] for i = 0..NUM_COEF-1, one per beat on a valid/ready output stream. Sits between a sample source and the downstream scaling/accumulate path, and generalises the fixed ×1/×3/×7/×8 selector in width, coefficient count and coefficient values, adding backpressure.

## Interface
- DATA_W, 8, input sample width
- NUM_COEF, 4, products emitted per sample (≥2)
- COEF_W, 4, width of each coefficient
- COEFS, 16'h8731, packed coefficients; COEF[i] = COEFS[i*COEF_W +: COEF_W]; default gives 1,3,7,8
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  sample offered
- in_data  input  DATA_W  sample
- in_ready  output  1  block can accept a sample
- input_grant  output  1  one-cycle pulse in the cycle after a sample is accepted
- out_valid  output  1  out_data holds a valid product
- out_ready  input  1  downstream accepts the beat
- out_data  output  DATA_W+COEF_W  product
- out_idx  output  $clog2(NUM_COEF)  coefficient index of the current beat
- out_last  output  1  current beat is index NUM_COEF-1

## Operation
- Reset (rst low, asynchronous): state IDLE, d_reg=0, out_valid=0, out_data=0, out_idx=0, out_last=0, input_grant=0. in_ready reads 1 once IDLE.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, except in the back-to-back case under Configuration.
- Accept: in_valid & in_ready at an edge. On that edge, the block latches d_reg=in_data, sets out_data=in_data×COEF[0], out_idx=0, out_valid=1, out_last=(NUM_COEF==1 ? 1 : 0), input_grant=1, and enters RUN.
- Beat transfer: out_valid & out_ready at an edge.
  - If idx<NUM_COEF-1: idx+1, out_data=d_reg×COEF[idx+1], out_last=(idx+1==NUM_COEF-1).
  - If last: out_valid=0, out_last=0, state IDLE (back-to-back case excepted).
- Stall: out_valid & !out_ready holds out_data, out_idx and out_last unchanged.
- in_valid while in_ready=0 is ignored. No grant is issued and no state changes.
- input_grant is 0 in every cycle except the single cycle after an accept.
- Arithmetic is unsigned. The product is zero-extended to DATA_W+COEF_W and never overflows. Max is (2^DATA_W-1)(2^COEF_W-1).
- A coefficient of 0 is legal and yields out_data=0 for that beat.
- Reset mid-sequence aborts the sample. Remaining beats are never emitted.

## Timing
- Latency: accept edge to first valid beat is 1 cycle.
- Throughput with out_ready held high: NUM_COEF beats per sample, plus 1 idle cycle between samples when _EN is off.
- Products are registered. No combinational path from in_data or out_ready to out_data.
- in_ready is combinational from state, out_valid, out_ready and out_last.

## Configuration
- MULTI_SEL_B2B_EN defined:
  - in_ready also =1 in RUN when out_valid & out_ready & out_last.
  - A sample accepted on that edge loads directly as beat 0, giving zero bubble between samples.
- Undefined: in_ready only in IDLE, so there is one dead cycle between the last beat and the next accept.

## Structure
- Package multi_sel_pkg holds:
  - state enum (IDLE, RUN)
  - default COEFS constant
  - default widths
- Sub-module const_shift_add_mul: combinational DATA_W × COEF_W unsigned multiply built from shifted adds of the set coefficient bits. The coefficient is selected by the sequencer. It is instantiated once, and its output is registered in multi_sel_seq.

## Test plan
- Reset release, then in_data=5 with out_ready=1 -> input_grant pulse; out_data 5,15,35,40 on consecutive cycles; out_idx 0..3; out_last only with 40.
- in_data=255 -> 255,765,1785,2040, all within 12 bits.
- in_data=5, out_ready low for 3 cycles while out_idx=1 -> out_data holds 15 for 3 cycles, then 35,40; no beat lost or duplicated.
- in_valid held with samples 5 then 6, out_ready=1:
  - B2B_EN set: 8 consecutive valid beats (5,15,35,40,6,18,42,48).
  - B2B_EN unset: 1-cycle out_valid gap before 6.
- rst driven low while out_idx=2 -> all outputs 0 immediately; after release in_ready=1; the next sample starts at idx 0.
- in_valid pulsed with in_data=9 while in RUN -> no input_grant; the current sequence is unaltered; the 9 is never emitted.
